// File: rtl/led_matrix_column_scanner_pkg.sv
// led_matrix_column_scanner_pkg: matrix geometry, FSM encodings and column select helper
package led_matrix_column_scanner_pkg;

    localparam int NUM_COLS  = 5;
    localparam int NUM_ROWS  = 7;
    localparam int COL_IDX_W = 3;
    localparam int FRAME_W   = NUM_COLS * NUM_ROWS;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    function automatic logic [NUM_COLS-1:0] col_onehot(input logic [COL_IDX_W-1:0] c);
        return NUM_COLS'(1) << c;
    endfunction

endpackage

// File: rtl/led_matrix_column_scanner_scan_slot_counter.sv
// scan_slot_counter: modulo-CLK_DIV slot counter with sync clear and blank/slot end strobes
module scan_slot_counter #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16,
    localparam int CNT_W       = $clog2(CLK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic blank_done_o,
    output logic slot_done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign blank_done_o = cnt_q == CNT_W'(BLANK_CYCLES - 1);
    assign slot_done_o  = cnt_q == CNT_W'(CLK_DIV - 1);

    always_comb cnt_d = (clr_i || slot_done_o) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk)
        cnt_q <= !rst_n ? '0 : cnt_d;

endmodule

// File: rtl/led_matrix_column_scanner.sv
// led_matrix_column_scanner: blank/drive column multiplexer for the 5x7 status matrix
// with a frame buffer captured once per frame so mid-frame updates never tear.
module led_matrix_column_scanner
    import led_matrix_column_scanner_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ROW_ACT_LOW  = 1'b1,
    parameter bit COL_ACT_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [FRAME_W-1:0]   frame_in,
    output logic [NUM_COLS-1:0]  cols_out,
    output logic [NUM_ROWS-1:0]  rows_out,
    output logic [COL_IDX_W-1:0] col_index,
    output logic                 frame_start
);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= CLK_DIV) begin : g_bad_params
        $error("led_matrix_column_scanner: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < CLK_DIV");
    end

    localparam logic [NUM_COLS-1:0] COLS_IDLE = {NUM_COLS{COL_ACT_LOW}};
    localparam logic [NUM_ROWS-1:0] ROWS_IDLE = {NUM_ROWS{ROW_ACT_LOW}};

    logic [1:0]           state_q, state_d;
    logic [COL_IDX_W-1:0] col_q, col_d;
    logic [FRAME_W-1:0]   buf_q, buf_d;
    logic [NUM_COLS-1:0]  cols_d;
    logic [NUM_ROWS-1:0]  rows_d;
    logic                 blank_done, slot_done, slot_end, wrap, capture, drive;

    scan_slot_counter #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (!enable || state_q == ST_OFF),
        .blank_done_o (blank_done),
        .slot_done_o  (slot_done)
    );

    always_comb begin
        slot_end = state_q == ST_DRIVE && slot_done;
        wrap     = slot_end && col_q == COL_IDX_W'(NUM_COLS - 1);
        capture  = enable && (state_q == ST_OFF || wrap);
        state_d  = !enable               ? ST_OFF   :
                   state_q == ST_OFF     ? ST_BLANK :
                   state_q == ST_BLANK   ? (blank_done ? ST_DRIVE : ST_BLANK) :
                                           (slot_done  ? ST_BLANK : ST_DRIVE);
        col_d    = (!enable || state_q == ST_OFF || wrap) ? '0 :
                   slot_end ? col_q + 1'b1 : col_q;
        buf_d    = capture ? frame_in : buf_q;
        drive    = state_d == ST_DRIVE;
        // Outputs are registered from next-state values so they change on the FSM edge.
        cols_d   = (drive ? col_onehot(col_d) : '0) ^ COLS_IDLE;
        rows_d   = (drive ? buf_d[NUM_ROWS*col_d +: NUM_ROWS] : '0) ^ ROWS_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            col_q       <= '0;
            buf_q       <= '0;
            cols_out    <= COLS_IDLE;
            rows_out    <= ROWS_IDLE;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            buf_q       <= buf_d;
            cols_out    <= cols_d;
            rows_out    <= rows_d;
            frame_start <= capture;
        end
    end

    assign col_index = col_q;

endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// tb_led_matrix_column_scanner: directed and random scan checks against a time-based reference model
module tb_led_matrix_column_scanner;

    localparam int CLK_DIV = 8;
    localparam int BLANK   = 2;
    localparam int FRAME   = 5 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n, enable;
    logic [34:0] frame_in;
    logic [4:0]  cols_out;
    logic [6:0]  rows_out;
    logic [2:0]  col_index;
    logic        frame_start;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference: while scanning, everything follows from cycles elapsed since scan start.
    bit          m_on;
    int          m_t;
    logic [34:0] m_buf;
    bit          m_fs;

    led_matrix_column_scanner #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK),
        .ROW_ACT_LOW  (1'b1),
        .COL_ACT_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_in    (frame_in),
        .cols_out    (cols_out),
        .rows_out    (rows_out),
        .col_index   (col_index),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_on = 0; m_t = 0; m_buf = '0; m_fs = 0;
        end else if (!enable) begin
            m_on = 0; m_t = 0; m_fs = 0;
        end else if (!m_on) begin
            m_on = 1; m_t = 0; m_buf = frame_in; m_fs = 1;
        end else begin
            m_t++;
            m_fs = (m_t % FRAME) == 0;
            if (m_fs) m_buf = frame_in;
        end
    endtask

    task automatic check_all();
        int          col;
        bit          drv;
        logic [4:0]  ec;
        logic [6:0]  er;
        col = m_on ? (m_t / CLK_DIV) % 5 : 0;
        drv = m_on && (m_t % CLK_DIV) >= BLANK;
        ec  = drv ? ~(5'b1 << col) : 5'h1F;
        er  = drv ? ~m_buf[7*col +: 7] : 7'h7F;
        chk("cols_out", 32'(cols_out), 32'(ec));
        chk("rows_out", 32'(rows_out), 32'(er));
        chk("col_index", 32'(col_index), 32'(col));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic goto_t(input int tt);
        int guard = 0;
        while (m_t != tt && guard < 2 * FRAME) begin
            step(1);
            guard++;
        end
    endtask

    task automatic restart();
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        step(1);
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        frame_in = '0;
        m_on = 0; m_t = 0; m_buf = '0; m_fs = 0;
        step(4);
        chk("reset_cols", 32'(cols_out), 32'h1F);
        chk("reset_rows", 32'(rows_out), 32'h7F);

        // Scan order with a distinct image per column
        frame_in = {7'h05, 7'h04, 7'h03, 7'h02, 7'h01};
        rst_n    = 1'b1;
        step(1);
        chk("first_frame_start", 32'(frame_start), 32'h1);
        goto_t(BLANK);
        chk("col0_rows", 32'(rows_out), 32'h7E);
        goto_t(4 * CLK_DIV + BLANK);
        chk("col4_rows", 32'(rows_out), 32'h7A);
        goto_t(FRAME);
        chk("wrap_frame_start", 32'(frame_start), 32'h1);
        chk("wrap_col", 32'(col_index), 32'h0);

        // Anti-tearing: new image arrives during column 1 drive
        goto_t(FRAME + CLK_DIV + BLANK);
        frame_in = {$urandom, $urandom};
        goto_t(2 * FRAME + CLK_DIV);

        // Random frames and occasional enable drops
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) frame_in = {$urandom, $urandom};
            enable = $urandom_range(60) != 0;
            step(1);
        end
        enable = 1'b1;

        // Enable drop during column 2 drive, then re-enable
        restart();
        goto_t(2 * CLK_DIV + BLANK + 1);
        enable = 1'b0;
        step(1);
        chk("drop_cols", 32'(cols_out), 32'h1F);
        chk("drop_col", 32'(col_index), 32'h0);
        enable = 1'b1;
        step(1);
        chk("reenable_fs", 32'(frame_start), 32'h1);
        step(CLK_DIV);

        // Sync reset during column 3: nothing moves before the edge
        goto_t(3 * CLK_DIV + BLANK + 1);
        rst_n = 1'b0;
        #1;
        check_all();
        step(1);
        rst_n = 1'b1;
        step(2 * CLK_DIV);

        // Column 4 images from the status decoder
        frame_in[34:28] = 7'h7F;
        restart();
        goto_t(4 * CLK_DIV + BLANK);
        chk("status00_rows", 32'(rows_out), 32'h00);
        frame_in[34:28] = 7'h01;
        restart();
        goto_t(4 * CLK_DIV + BLANK);
        chk("status01_rows", 32'(rows_out), 32'h7E);
        frame_in[34:28] = 7'h45;
        restart();
        goto_t(4 * CLK_DIV + BLANK);
        chk("status10_rows", 32'(rows_out), 32'h3A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
